// File: rtl/leaf_hub_pkg.sv
// Shared definitions for the leaf hub: physical word layout helpers,
// the channel index type and the stage-controller channel number.
package leaf_hub_pkg;

  // Stage controller always occupies channel 0.
  localparam int SC_CHANNEL = 0;

  // Generic channel index, wide enough for any practical channel count.
  typedef logic [7:0] chan_idx_t;

  // Physical word is {fpga_id, chan_id, payload}, MSB first.
  function automatic int phys_width(input int fpgaid_w, input int idw, input int hw);
    return fpgaid_w + idw + hw;
  endfunction

  // LSB position of the channel ID field.
  function automatic int chan_lsb(input int hw);
    return hw;
  endfunction

  // LSB position of the FPGA ID field.
  function automatic int fid_lsb(input int idw, input int hw);
    return idw + hw;
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// CH-input round-robin arbiter with optional stage-controller priority.
// The pointer moves past the winner only when the grant is taken.
module leaf_rr_arbiter
  import leaf_hub_pkg::*;
#(
  parameter int CH          = 7,
  parameter int IDX_W       = 3,
  parameter int SC_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    req,
  input  logic             advance,
  output logic [CH-1:0]    grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] rr_ptr;

  // Pick the first requester at or after rr_ptr, wrapping; channel 0 may override.
  always_comb begin
    int c;
    c           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (SC_PRIORITY != 0 && req[SC_CHANNEL]) begin
      grant[SC_CHANNEL] = 1'b1;
      grant_idx         = IDX_W'(SC_CHANNEL);
      grant_valid       = 1'b1;
    end else begin
      for (int k = 0; k < CH; k++) begin
        c = int'(rr_ptr) + k;
        if (c >= CH) c = c - CH;
        if (!grant_valid && req[c]) begin
          grant[c]    = 1'b1;
          grant_idx   = IDX_W'(c);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Advance the pointer to the channel after the one just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= (grant_idx == IDX_W'(CH - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/leaf_hub_arbiter.sv
// Leaf-side hub: merges the stage-controller and grid FIFO channels onto
// one uplink, routes the downlink back by channel ID, drops mis-addressed
// words, and reports a stretched activity flag for convergence checking.
module leaf_hub_arbiter
  import leaf_hub_pkg::*;
#(
  parameter int FIFO_COUNT     = 6,
  parameter int HUB_FIFO_WIDTH = 16,
  parameter int FPGAID_WIDTH   = 4,
  parameter int FIFO_IDWIDTH   = 3,
  parameter int MY_ID          = 1,
  parameter int SC_PRIORITY    = 0,
  parameter int FLYING_DELAY   = 4,
  localparam int CH     = FIFO_COUNT + 1,
  localparam int PHYS_W = phys_width(FPGAID_WIDTH, FIFO_IDWIDTH, HUB_FIFO_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CH*HUB_FIFO_WIDTH-1:0] loc_out_data,
  input  logic [CH-1:0]                loc_out_valid,
  output logic [CH-1:0]                loc_out_ready,
  output logic [CH*HUB_FIFO_WIDTH-1:0] loc_in_data,
  output logic [CH-1:0]                loc_in_valid,
  input  logic [CH-1:0]                loc_in_ready,
  output logic [PHYS_W-1:0]            link_out_data,
  output logic                         link_out_valid,
  input  logic                         link_out_ready,
  input  logic [PHYS_W-1:0]            link_in_data,
  input  logic                         link_in_valid,
  output logic                         link_in_ready,
  output logic                         has_flying_messages,
  output logic                         bad_dest,
  output logic [15:0]                  drop_count
);

  localparam int CNT_W   = $clog2(FLYING_DELAY + 1);
  localparam int CH_LSB  = chan_lsb(HUB_FIFO_WIDTH);
  localparam int FID_LSB = fid_lsb(FIFO_IDWIDTH, HUB_FIFO_WIDTH);

  logic                      load_en;
  logic                      xfer;
  logic [CH-1:0]             grant;
  logic [FIFO_IDWIDTH-1:0]   grant_idx;
  logic                      grant_valid;
  logic [HUB_FIFO_WIDTH-1:0] sel_payload;
  logic                      out_vld_p1;
  logic [PHYS_W-1:0]         out_data_p1;

  logic                      in_vld_p1;
  logic [PHYS_W-1:0]         in_data_p1;
  logic [FPGAID_WIDTH-1:0]   in_fid;
  logic [FIFO_IDWIDTH-1:0]   in_ch;
  logic                      bad_word;
  logic                      in_consume;
  logic                      capture;

  logic                      activity;
  logic [CNT_W-1:0]          fly_cnt;

  // Outbound stage 0 -> 1: arbitration into the uplink register
  assign load_en       = ~reset & (~out_vld_p1 | link_out_ready);
  assign loc_out_ready = grant & {CH{load_en}};
  assign xfer          = load_en & grant_valid;

  leaf_rr_arbiter #(
    .CH          (CH),
    .IDX_W       (FIFO_IDWIDTH),
    .SC_PRIORITY (SC_PRIORITY)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (loc_out_valid),
    .advance     (load_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Route the granted channel's payload toward the uplink register.
  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) sel_payload = loc_out_data[i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
    end
  end

  // Uplink valid: refilled whenever the register is empty or being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_p1 <= 1'b0;
    end else if (load_en) begin
      out_vld_p1 <= grant_valid;
    end
  end

  // Uplink word: tag the payload with our FPGA ID and the source channel.
  always_ff @(posedge clk) begin
    if (xfer) out_data_p1 <= {FPGAID_WIDTH'(MY_ID), grant_idx, sel_payload};
  end

  assign link_out_valid = out_vld_p1;
  assign link_out_data  = out_data_p1;

  // Inbound stage 0 -> 1: downlink capture, decode and local delivery
  assign in_fid   = in_data_p1[FID_LSB +: FPGAID_WIDTH];
  assign in_ch    = in_data_p1[CH_LSB +: FIFO_IDWIDTH];
  assign bad_word = (in_fid != FPGAID_WIDTH'(MY_ID)) | (int'(in_ch) >= CH);

  // One-hot delivery to the addressed channel; bad words are never presented.
  always_comb begin
    loc_in_valid = '0;
    for (int i = 0; i < CH; i++) begin
      loc_in_valid[i] = in_vld_p1 & ~bad_word & (in_ch == FIFO_IDWIDTH'(i));
    end
  end

  assign in_consume    = in_vld_p1 & (bad_word | (|(loc_in_valid & loc_in_ready)));
  assign link_in_ready = ~reset & (~in_vld_p1 | in_consume);
  assign capture       = link_in_valid & link_in_ready;
  assign loc_in_data   = {CH{in_data_p1[HUB_FIFO_WIDTH-1:0]}};

  // Downlink valid: a new capture takes precedence over the consume of the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld_p1 <= 1'b0;
    end else if (capture) begin
      in_vld_p1 <= 1'b1;
    end else if (in_consume) begin
      in_vld_p1 <= 1'b0;
    end
  end

  // Downlink word register.
  always_ff @(posedge clk) begin
    if (capture) in_data_p1 <= link_in_data;
  end

  // Sticky error flag and saturating drop counter for mis-addressed words.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_dest   <= 1'b0;
      drop_count <= '0;
    end else if (in_vld_p1 && bad_word) begin
      bad_dest <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign activity = (|loc_out_valid) | out_vld_p1 | in_vld_p1 | link_in_valid;

  // Hold the flying flag for FLYING_DELAY idle cycles after the last activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      fly_cnt <= '0;
    end else if (activity) begin
      fly_cnt <= CNT_W'(FLYING_DELAY);
    end else if (fly_cnt != '0) begin
      fly_cnt <= fly_cnt - CNT_W'(1);
    end
  end

  assign has_flying_messages = activity | (fly_cnt != '0);

endmodule

// File: tb/tb_leaf_hub_arbiter.sv
// Bench for leaf_hub_arbiter: a round-robin instance and a stage-controller
// priority instance share the same stimulus and are compared each cycle
// against a behavioural model of the hub.
module tb_leaf_hub_arbiter;

  localparam int CH    = 7;
  localparam int HW    = 16;
  localparam int PW    = 23;
  localparam int MY_ID = 1;
  localparam int FD    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*HW-1:0]  lod;
  logic [CH-1:0]     lov;
  logic [CH-1:0]     lir;
  logic              loready;
  logic [PW-1:0]     lidata;
  logic              livalid;

  logic [CH-1:0]     o_lor   [2];
  logic [CH*HW-1:0]  o_lid   [2];
  logic [CH-1:0]     o_liv   [2];
  logic [PW-1:0]     o_lod   [2];
  logic              o_lov   [2];
  logic              o_lirdy [2];
  logic              o_fly   [2];
  logic              o_bad   [2];
  logic [15:0]       o_drops [2];

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = round-robin instance, 1 = priority instance
  bit          m_ovld  [2];
  logic [PW-1:0] m_odata [2];
  int          m_ptr   [2];
  int          m_cnt   [2];
  bit          m_ivld;
  logic [PW-1:0] m_idata;
  bit          m_bad;
  int          m_drops;

  always #5 clk = ~clk;

  leaf_hub_arbiter #(.SC_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset),
    .loc_out_data(lod), .loc_out_valid(lov), .loc_out_ready(o_lor[0]),
    .loc_in_data(o_lid[0]), .loc_in_valid(o_liv[0]), .loc_in_ready(lir),
    .link_out_data(o_lod[0]), .link_out_valid(o_lov[0]), .link_out_ready(loready),
    .link_in_data(lidata), .link_in_valid(livalid), .link_in_ready(o_lirdy[0]),
    .has_flying_messages(o_fly[0]), .bad_dest(o_bad[0]), .drop_count(o_drops[0])
  );

  leaf_hub_arbiter #(.SC_PRIORITY(1)) dut_pri (
    .clk(clk), .reset(reset),
    .loc_out_data(lod), .loc_out_valid(lov), .loc_out_ready(o_lor[1]),
    .loc_in_data(o_lid[1]), .loc_in_valid(o_liv[1]), .loc_in_ready(lir),
    .link_out_data(o_lod[1]), .link_out_valid(o_lov[1]), .link_out_ready(loready),
    .link_in_data(lidata), .link_in_valid(livalid), .link_in_ready(o_lirdy[1]),
    .has_flying_messages(o_fly[1]), .bad_dest(o_bad[1]), .drop_count(o_drops[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < CH; i++) lod[i*HW +: HW] = 16'($urandom);
  endtask

  // One clock: check outputs at the falling edge against the model, then
  // advance the model with the inputs that the rising edge will see.
  task automatic step(input bit do_chk);
    int g [2];
    bit ld [2];
    bit act [2];
    int ch, fid, c;
    bit bad, cons, lirdy;
    logic [CH-1:0] exp_liv;
    @(negedge clk);
    fid = int'(m_idata[22:19]);
    ch  = int'(m_idata[18:16]);
    bad = (fid != MY_ID) || (ch >= CH);
    exp_liv = (m_ivld && !bad) ? CH'(1 << ch) : '0;
    cons  = m_ivld && (bad || (lir[ch] === 1'b1));
    lirdy = !reset && (!m_ivld || cons);
    for (int i = 0; i < 2; i++) begin
      ld[i] = !reset && (!m_ovld[i] || loready);
      g[i]  = -1;
      if (i == 1 && lov[0]) g[i] = 0;
      else begin
        for (int k = 0; k < CH; k++) begin
          c = (m_ptr[i] + k) % CH;
          if (g[i] < 0 && lov[c]) g[i] = c;
        end
      end
      act[i] = (lov != '0) || m_ovld[i] || m_ivld || livalid;
    end
    if (do_chk) begin
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "rr_grant" : "pri_grant", o_lor[i],
            (g[i] >= 0 && ld[i]) ? 128'(1 << g[i]) : 128'd0);
        chk("link_out_valid", o_lov[i], m_ovld[i]);
        if (m_ovld[i]) chk("link_out_data", o_lod[i], m_odata[i]);
        chk("flying", o_fly[i], act[i] || (m_cnt[i] != 0));
      end
      chk("loc_in_valid", o_liv[0], exp_liv);
      chk("link_in_ready", o_lirdy[0], lirdy);
      if (exp_liv != '0) chk("loc_in_data", o_lid[0], {CH{m_idata[15:0]}});
      chk("bad_dest", o_bad[0], m_bad);
      chk("drop_count", o_drops[0], m_drops);
    end
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_ovld[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      end
      m_ivld = 0; m_bad = 0; m_drops = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ld[i]) begin
          m_ovld[i] = (g[i] >= 0);
          if (g[i] >= 0) begin
            m_odata[i] = {4'(MY_ID), 3'(g[i]), lod[g[i]*HW +: HW]};
            m_ptr[i]   = (g[i] + 1) % CH;
          end
        end
        m_cnt[i] = act[i] ? FD : (m_cnt[i] > 0 ? m_cnt[i] - 1 : 0);
      end
      if (m_ivld && bad) begin
        m_bad = 1;
        if (m_drops < 65535) m_drops++;
      end
      if (lirdy && livalid) begin
        m_ivld = 1; m_idata = lidata;
      end else if (cons) m_ivld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ovld[i] = 0; m_odata[i] = '0; m_ptr[i] = 0; m_cnt[i] = 0;
    end
    m_ivld = 0; m_idata = '0; m_bad = 0; m_drops = 0;
    reset = 1'b1; lov = '0; lir = '0; loready = 1'b1; lidata = '0; livalid = 1'b0;
    rand_payloads();
    step(0);
    step(1);
    step(1);

    // All channels requesting: round-robin sweep 0..6, 0
    reset = 1'b0;
    lov = 7'h7F;
    for (int n = 0; n < 9; n++) begin
      rand_payloads();
      step(1);
    end
    lov = '0;
    step(1); step(1);

    // Channels 0 and 3 contending, then only 3
    lov = 7'b0001001;
    for (int n = 0; n < 4; n++) begin rand_payloads(); step(1); end
    lov = 7'b0001000;
    step(1); step(1);
    lov = '0;
    step(1); step(1);

    // Uplink stall with a word pending and another channel waiting
    lov = 7'b0000100; rand_payloads();
    step(1);
    lov = 7'b0010000; loready = 1'b0; rand_payloads();
    for (int n = 0; n < 5; n++) step(1);
    loready = 1'b1;
    step(1);
    lov = '0;
    step(1); step(1); step(1);

    // Downlink to channel 5 while the destination is not ready
    livalid = 1'b1; lidata = {4'(MY_ID), 3'd5, 16'hABCD}; lir = '0;
    step(1);
    lidata = {4'(MY_ID), 3'd5, 16'h1234};
    for (int n = 0; n < 3; n++) step(1);
    lir = 7'b0100000;
    step(1); step(1);
    livalid = 1'b0;
    step(1); step(1);

    // Mis-addressed words: wrong FPGA ID, then channel out of range
    lir = 7'h7F; livalid = 1'b1;
    lidata = {4'(MY_ID + 1), 3'd2, 16'h1111};
    step(1);
    lidata = {4'(MY_ID), 3'd7, 16'h2222};
    step(1);
    livalid = 1'b0;
    step(1); step(1);
    chk("drops_after_two_bad", o_drops[0], 16'd2);
    chk("bad_dest_sticky", o_bad[0], 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk("drops_cleared", o_drops[0], 16'd0);
    chk("bad_dest_cleared", o_bad[0], 1'b0);

    // Single outbound word, then idle long enough for the flag to drop
    lov = 7'b0000010; rand_payloads();
    step(1);
    lov = '0;
    for (int n = 0; n < 8; n++) step(1);
    chk("flying_settled", o_fly[0], 1'b0);

    // Randomized traffic on both paths with occasional resets
    for (int n = 0; n < 400; n++) begin
      lov     = CH'($urandom);
      lir     = CH'($urandom);
      loready = ($urandom_range(3) != 0);
      livalid = ($urandom_range(1) != 0);
      lidata  = {($urandom_range(7) == 0) ? 4'(MY_ID + 1) : 4'(MY_ID),
                 3'($urandom_range(7)), 16'($urandom)};
      reset   = ($urandom_range(99) == 0);
      rand_payloads();
      step(1);
    end
    reset = 1'b0; lov = '0; livalid = 1'b0;
    for (int n = 0; n < 8; n++) step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leaf_hub_arbiter.md
Name: leaf_hub_arbiter

Overview:
Parametrised leaf-side interconnect hub that replaces the fixed final arbitration stage. It merges the stage-controller channel and FIFO_COUNT grid master FIFOs onto one physical uplink using registered round-robin arbitration, with an optional stage-controller priority mode. It demultiplexes the physical downlink back to local channels by channel ID, drops and counts mis-addressed words, and produces a stretched has_flying_messages flag for the stage controller's convergence check.

Parameters:
FIFO_COUNT, 6, number of grid master FIFO channels; total channels CH = FIFO_COUNT+1, and channel 0 is the stage controller.
HUB_FIFO_WIDTH, 16, payload width per channel.
FPGAID_WIDTH, 4, FPGA ID field width.
FIFO_IDWIDTH, 3, channel ID field width; must satisfy 2**FIFO_IDWIDTH >= CH.
MY_ID, 1, this leaf's FPGA ID.
SC_PRIORITY, 0, 1 = channel 0 wins arbitration whenever it is valid.
FLYING_DELAY, 4, number of idle cycles has_flying_messages stays high after the last activity; must be >= 1.
Derived: PHYS_W = FPGAID_WIDTH+FIFO_IDWIDTH+HUB_FIFO_WIDTH. Physical word = {fpga_id, chan_id, payload}, MSB first.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
loc_out_data  in  CH*HUB_FIFO_WIDTH  local-to-link payloads, channel i at slice [i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH]
loc_out_valid  in  CH  per-channel valid
loc_out_ready  out  CH  per-channel ready (grant)
loc_in_data  out  CH*HUB_FIFO_WIDTH  inbound payload, replicated into every slice
loc_in_valid  out  CH  one-hot inbound valid
loc_in_ready  in  CH  per-channel ready
link_out_data  out  PHYS_W  uplink word
link_out_valid  out  1  uplink valid
link_out_ready  in  1  uplink ready
link_in_data  in  PHYS_W  downlink word
link_in_valid  in  1  downlink valid
link_in_ready  out  1  downlink ready
has_flying_messages  out  1  activity flag, stretched by FLYING_DELAY cycles
bad_dest  out  1  sticky flag: a mis-addressed word was dropped
drop_count  out  16  saturating count of dropped words

Behaviour:
- Reset values: link_out_valid=0, loc_in_valid=0, bad_dest=0, drop_count=0, has_flying_messages=0. Round-robin pointer resets to 0 and the flying counter resets to 0. Data registers are don't-care.
- Outbound path:
  - One output register; load_en = ~out_valid | link_out_ready.
  - Arbiter selects the first valid channel at or after rr_ptr, wrapping modulo CH. With SC_PRIORITY=1, channel 0 overrides whenever it is valid.
  - loc_out_ready = onehot(grant) & {CH{load_en}}. loc_out_ready is 0 for every channel when none is valid.
  - On a transfer from channel g: link_out_data <= {MY_ID, g, payload_g}, and rr_ptr <= (g+1) mod CH.
  - Latency is 1 cycle from accepted local valid to link_out_valid. Throughput is 1 word/cycle while link_out_ready=1.
  - link_out_data stays stable while link_out_valid=1 and link_out_ready=0.
- Inbound path:
  - One input register; link_in_ready = ~in_valid | in_consume.
  - On a captured word, decode fid = fpga_id field and ch = chan_id field. The word is bad if fid != MY_ID or ch >= CH.
  - Good word: loc_in_valid = onehot(ch) while held. in_consume = loc_in_ready[ch].
  - Bad word: loc_in_valid=0 and in_consume=1 on the cycle after capture (dropped). On the drop, bad_dest <= 1 and drop_count increments, saturating at 16'hFFFF.
  - Latency is 1 cycle from link handshake to loc_in_valid. Back-to-back words sustain 1 word/cycle while the destination is ready.
- Flying flag:
  - activity = |loc_out_valid | out_valid | in_valid | link_in_valid.
  - If activity, cnt <= FLYING_DELAY; else if cnt != 0, cnt <= cnt-1.
  - has_flying_messages = activity | (cnt != 0), combinational from registers and inputs.
- Simultaneous events:
  - Output register unload and reload in the same cycle is allowed, with no bubble.
  - An inbound consume and a new capture in the same cycle is allowed.
  - Outbound and inbound paths are fully independent.
- Reset mid-operation: in-flight words in both registers are discarded, and bad_dest and drop_count clear. No handshake completes in the reset cycle; all readies are forced to 0 while reset=1.

Decomposition:
- Shared package: PHYS_W and field-offset functions, channel index type, and SC_CHANNEL = 0 constant.
- One sub-module: leaf_rr_arbiter (CH-input round-robin with priority override and pointer update on grant).
- Register slices stay inline.

Test Plan:
- Reset, then all loc_out_valid high (CH=7), link_out_ready=1 -> grants 0,1,2,...,6,0 on consecutive cycles. The first link_out_valid appears 1 cycle after the first grant, and chan_id fields follow the same sequence.
- SC_PRIORITY=1, channels 0 and 3 both held valid for 4 cycles -> channel 0 granted all 4 cycles and channel 3 only after channel 0 drops. With SC_PRIORITY=0 -> alternating 0,3,0,3.
- link_out_ready=0 for 5 cycles with a word pending -> link_out_data stable, every loc_out_ready=0. Ready returns -> the word is sent exactly once.
- Downlink {MY_ID,5,16'hABCD} with loc_in_ready[5]=0 for 3 cycles -> loc_in_valid=7'b0100000 held for 3 cycles, link_in_ready=0 for the following word, then one delivery when ready rises.
- Downlink {MY_ID+1,2,x} then {MY_ID,7,x} (CH=7) -> both dropped, bad_dest=1, drop_count=2, no loc_in_valid. Reset -> both clear.
- Single word out then idle, FLYING_DELAY=4 -> has_flying_messages high while active plus exactly 4 idle cycles, then 0.
